// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: fetch FSM states, reset defaults and
// MIPS instruction field bit positions (also used by the decode stage).
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int JADDR_HI  = 25;
  localparam int JADDR_LO  = 0;

  // Sequential PC increment; wraps modulo 2^32, low bits pass through untouched.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold has priority, then capture, then bubble.
// A bubble loads the configured NOP word and clears valid.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        bubble,
  input  logic        hold,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_plus4_d,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= NOP_WORD;
      pc_plus4 <= 32'h0;
    end else if (!hold) begin
      if (capture) begin
        valid    <= 1'b1;
        instr    <= instr_d;
        pc_plus4 <= pc_plus4_d;
      end else if (bubble) begin
        valid    <= 1'b0;
        instr    <= NOP_WORD;
        pc_plus4 <= 32'h0;
      end
    end
  end

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS instruction fetch stage: PC, BOOT/RUN/WAIT fetch FSM, pending redirect
// and IF/ID register. Optional macro DELAY_SLOT_EN keeps the word fetched
// alongside a redirect as a valid delay-slot instruction.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16,
  output logic [25:0] id_jaddr
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         pend_reg, pend_next;
  logic [31:0]  pend_target_reg, pend_target_next;
  logic         ifid_capture, ifid_bubble, ifid_hold;
  logic         redirect_slot_capture;

`ifdef DELAY_SLOT_EN
  assign redirect_slot_capture = 1'b1;
`else
  assign redirect_slot_capture = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      pend_reg        <= 1'b0;
      pend_target_reg <= RESET_PC;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_reg        <= pend_next;
      pend_target_reg <= pend_target_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BOOT:    state_next = RUN;
      RUN:     if (!redirect && !stall && !imem_ready) state_next = WAIT;
      WAIT:    if (imem_ready && (redirect || !stall)) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    case (state_reg)
      RUN, WAIT: imem_req = 1'b1;
      default:   imem_req = 1'b0;
    endcase
  end

  // PC, pending-redirect and IF/ID control; redirect outranks stall.
  always_comb begin
    pc_next          = pc_reg;
    pend_next        = pend_reg;
    pend_target_next = pend_target_reg;
    ifid_capture     = 1'b0;
    ifid_bubble      = 1'b0;
    ifid_hold        = 1'b1;
    case (state_reg)
      RUN: begin
        if (redirect) begin
          pc_next      = redirect_target;
          ifid_hold    = 1'b0;
          ifid_capture = redirect_slot_capture && imem_ready;
          ifid_bubble  = !(redirect_slot_capture && imem_ready);
        end else if (!stall) begin
          ifid_hold = 1'b0;
          if (imem_ready) begin
            ifid_capture = 1'b1;
            pc_next      = pc_inc(pc_reg);
          end else begin
            ifid_bubble = 1'b1;
          end
        end
      end
      WAIT: begin
        if (redirect || !stall) begin
          ifid_hold = 1'b0;
          if (imem_ready) begin
            if (redirect || pend_reg) begin
              // The arriving word belongs to the old path; the newest target wins.
              pc_next      = redirect ? redirect_target : pend_target_reg;
              pend_next    = 1'b0;
              ifid_capture = redirect_slot_capture;
              ifid_bubble  = !redirect_slot_capture;
            end else begin
              ifid_capture = 1'b1;
              pc_next      = pc_inc(pc_reg);
            end
          end else begin
            ifid_bubble = 1'b1;
            if (redirect) begin
              pend_next        = 1'b1;
              pend_target_next = redirect_target;
            end
          end
        end
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_reg;

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .capture    (ifid_capture),
    .bubble     (ifid_bubble),
    .hold       (ifid_hold),
    .instr_d    (imem_rdata),
    .pc_plus4_d (pc_inc(pc_reg)),
    .valid      (id_valid),
    .instr      (id_instr),
    .pc_plus4   (id_pc_plus4)
  );

  assign id_opcode = id_instr[OPCODE_HI:OPCODE_LO];
  assign id_rs     = id_instr[RS_HI:RS_LO];
  assign id_rt     = id_instr[RT_HI:RT_LO];
  assign id_rd     = id_instr[RD_HI:RD_LO];
  assign id_funct  = id_instr[FUNCT_HI:FUNCT_LO];
  assign id_imm16  = id_instr[IMM_HI:IMM_LO];
  assign id_jaddr  = id_instr[JADDR_HI:JADDR_LO];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed, table-driven bench for instr_fetch_stage; memory returns word = address.
module tb_instr_fetch_stage;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        Clk;
  logic        Reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
  logic [25:0] id_jaddr;
  logic        special;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_stage dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc_plus4     (id_pc_plus4),
    .id_opcode       (id_opcode),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rd           (id_rd),
    .id_funct        (id_funct),
    .id_imm16        (id_imm16),
    .id_jaddr        (id_jaddr)
  );

  // Memory model: word equals its address, except one injected load instruction.
  assign imem_rdata = special ? 32'h8C22_FFFC : imem_addr;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        rdr;
    logic        sp;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
  } vec_t;

  localparam int NV = 31;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rdy, input logic stl, input logic rdr,
                              input logic sp, input logic [31:0] tgt,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_instr,
                              input logic [31:0] e_pc4);
    vec_t v;
    v.rdy = rdy; v.stl = stl; v.rdr = rdr; v.sp = sp; v.tgt = tgt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pc4 = e_pc4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  initial begin
    // Each row: inputs driven this cycle, outputs expected this cycle (before the edge).
    //                 rdy stl rdr sp  tgt           req addr          valid  instr             pc4
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         0,  32'h0,            32'h0);
    vecs[1]  = mk(1, 0, 0, 0, 32'h0,         1, 32'h0,         0,  32'h0,            32'h0);
    vecs[2]  = mk(1, 0, 0, 0, 32'h0,         1, 32'h4,         1,  32'h0,            32'h4);
    vecs[3]  = mk(1, 0, 0, 0, 32'h0,         1, 32'h8,         1,  32'h4,            32'h8);
    vecs[4]  = mk(1, 1, 0, 0, 32'h0,         1, 32'hC,         1,  32'h8,            32'hC);
    vecs[5]  = mk(1, 1, 0, 0, 32'h0,         1, 32'hC,         1,  32'h8,            32'hC);
    vecs[6]  = mk(1, 0, 0, 0, 32'h0,         1, 32'hC,         1,  32'h8,            32'hC);
    vecs[7]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h10,        1,  32'hC,            32'h10);
    vecs[8]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h10,        0,  32'h0,            32'h0);
    vecs[9]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h10,        0,  32'h0,            32'h0);
    vecs[10] = mk(1, 0, 0, 0, 32'h0,         1, 32'h10,        0,  32'h0,            32'h0);
    vecs[11] = mk(1, 0, 0, 0, 32'h0,         1, 32'h14,        1,  32'h10,           32'h14);
    vecs[12] = mk(1, 0, 0, 0, 32'h0,         1, 32'h18,        1,  32'h14,           32'h18);
    vecs[13] = mk(1, 0, 0, 0, 32'h0,         1, 32'h1C,        1,  32'h18,           32'h1C);
    vecs[14] = mk(1, 0, 1, 0, 32'h100,       1, 32'h20,        1,  32'h1C,           32'h20);
    vecs[15] = mk(1, 0, 0, 0, 32'h0,         1, 32'h100,       DS, DS ? 32'h20 : 0,  32'h24);
    vecs[16] = mk(1, 0, 1, 0, 32'h30,        1, 32'h104,       1,  32'h100,          32'h104);
    vecs[17] = mk(0, 0, 0, 0, 32'h0,         1, 32'h30,        DS, DS ? 32'h104 : 0, 32'h108);
    vecs[18] = mk(0, 0, 1, 0, 32'h200,       1, 32'h30,        0,  32'h0,            32'h0);
    vecs[19] = mk(0, 0, 0, 0, 32'h0,         1, 32'h30,        0,  32'h0,            32'h0);
    vecs[20] = mk(1, 0, 0, 0, 32'h0,         1, 32'h30,        0,  32'h0,            32'h0);
    vecs[21] = mk(1, 0, 0, 0, 32'h0,         1, 32'h200,       DS, DS ? 32'h30 : 0,  32'h34);
    vecs[22] = mk(1, 0, 0, 1, 32'h0,         1, 32'h204,       1,  32'h200,          32'h204);
    vecs[23] = mk(0, 0, 0, 0, 32'h0,         1, 32'h208,       1,  32'h8C22FFFC,     32'h208);
    vecs[24] = mk(0, 0, 1, 0, 32'h300,       1, 32'h208,       0,  32'h0,            32'h0);
    vecs[25] = mk(0, 0, 1, 0, 32'h400,       1, 32'h208,       0,  32'h0,            32'h0);
    vecs[26] = mk(1, 1, 0, 0, 32'h0,         1, 32'h208,       0,  32'h0,            32'h0);
    vecs[27] = mk(1, 0, 0, 0, 32'h0,         1, 32'h208,       0,  32'h0,            32'h0);
    vecs[28] = mk(1, 0, 1, 0, 32'hFFFFFFFC,  1, 32'h400,       DS, DS ? 32'h208 : 0, 32'h20C);
    vecs[29] = mk(1, 0, 0, 0, 32'h0,         1, 32'hFFFFFFFC,  DS, DS ? 32'h400 : 0, 32'h404);
    vecs[30] = mk(1, 0, 0, 0, 32'h0,         1, 32'h0,         1,  32'hFFFFFFFC,     32'h0);

    Reset_n = 1'b0;
    imem_ready = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;
    special = 1'b0;

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_req", {31'b0, imem_req}, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", {31'b0, id_valid}, 32'h0);
    chk("reset_instr", id_instr, 32'h0);
    chk("reset_pc4", id_pc_plus4, 32'h0);
    Reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      imem_ready = vecs[i].rdy;
      stall = vecs[i].stl;
      redirect = vecs[i].rdr;
      redirect_target = vecs[i].tgt;
      special = vecs[i].sp;
      @(negedge Clk);
      $display("row %0d: rdy=%0b stall=%0b redir=%0b addr=%08h valid=%0b instr=%08h",
               i, imem_ready, stall, redirect, imem_addr, id_valid, id_instr);
      chk($sformatf("row%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      chk($sformatf("row%0d_addr", i), imem_addr, vecs[i].e_addr);
      chk($sformatf("row%0d_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("row%0d_instr", i), id_instr, vecs[i].e_instr);
      if (vecs[i].e_valid)
        chk($sformatf("row%0d_pc4", i), id_pc_plus4, vecs[i].e_pc4);
      if (i == 8) begin
        chk("bubble_fields", {id_opcode, id_rs, id_rt, id_funct, id_jaddr[9:0]}, 32'h0);
        chk("bubble_imm", {16'h0, id_imm16}, 32'h0);
      end
      if (i == 23) begin
        chk("fld_opcode", {26'h0, id_opcode}, 32'h23);
        chk("fld_rs", {27'h0, id_rs}, 32'h1);
        chk("fld_rt", {27'h0, id_rt}, 32'h2);
        chk("fld_rd", {27'h0, id_rd}, 32'h1F);
        chk("fld_funct", {26'h0, id_funct}, 32'h3C);
        chk("fld_imm16", {16'h0, id_imm16}, 32'hFFFC);
        chk("fld_jaddr", {6'h0, id_jaddr}, 32'h022FFFC);
      end
      @(posedge Clk);
      #1;
    end

    // Reset asserted mid-cycle while a redirect is pending in WAIT.
    imem_ready = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    special = 1'b0;
    @(posedge Clk);
    #1;
    redirect = 1'b1;
    redirect_target = 32'h500;
    @(posedge Clk);
    #1;
    redirect = 1'b0;
    imem_ready = 1'b1;
    #2;
    Reset_n = 1'b0;
    #1;
    $display("async reset: req=%0b addr=%08h valid=%0b", imem_req, imem_addr, id_valid);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", {31'b0, id_valid}, 32'h0);
    chk("arst_instr", id_instr, 32'h0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("post_boot_req", {31'b0, imem_req}, 32'h0);
    @(negedge Clk);
    chk("post_run_req", {31'b0, imem_req}, 32'h1);
    chk("post_run_addr", imem_addr, 32'h0);
    chk("post_run_valid", {31'b0, id_valid}, 32'h0);
    @(negedge Clk);
    $display("after reset: addr=%08h valid=%0b instr=%08h", imem_addr, id_valid, id_instr);
    chk("post_addr4", imem_addr, 32'h4);
    chk("post_valid", {31'b0, id_valid}, 32'h1);
    chk("post_instr0", id_instr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage of the five-stage MIPS datapath. Holds the PC, issues fetch requests to instruction memory through a ready handshake, and registers each fetched word with PC+4 into the IF/ID pipeline register. Decoded fields are driven from that register, including `id_imm16`, which feeds the downstream 16-to-32 sign-extension unit in ID. Stall, redirect (branch/jump) and bubble insertion are handled here.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `NOP_WORD`, 32'h0000_0000, word driven on `id_instr` when `id_valid`=0 (sll $0,$0,0)
- `Clk`  in  1  clock, all state on rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address (= PC)
- `imem_rdata`  in  32  instruction word, valid when `imem_ready`=1
- `imem_ready`  in  1  word for `imem_addr` present this cycle
- `stall`  in  1  hazard unit: hold PC and IF/ID
- `redirect`  in  1  taken branch/jump resolved in ID
- `redirect_target`  in  32  new PC when `redirect`=1
- `id_valid`  out  1  IF/ID holds a real instruction
- `id_instr`  out  32  registered instruction
- `id_pc_plus4`  out  32  registered PC+4
- `id_opcode`  out  6  `id_instr[31:26]`
- `id_rs`, `id_rt`, `id_rd`  out  5 each  `[25:21]`, `[20:16]`, `[15:11]`
- `id_funct`  out  6  `[5:0]`
- `id_imm16`  out  16  `[15:0]`, to sign extension
- `id_jaddr`  out  26  `[25:0]`

## Operation
- FSM states:
  - BOOT: one cycle after reset release, `imem_req`=0.
  - BOOT→RUN unconditionally.
  - RUN: `imem_req`=1.
  - RUN→WAIT when `imem_ready`=0 and no redirect is applied.
  - WAIT: `imem_req`=1, `imem_addr` held stable.
  - WAIT→RUN when `imem_ready`=1.
- Handshake rule: while `imem_req` && !`imem_ready`, `imem_addr` must not change.
- RUN, `imem_ready`=1, no stall, no redirect: IF/ID ← {rdata, PC+4, valid=1}; PC ← PC+4.
- RUN, `imem_ready`=0: PC held; IF/ID ← bubble (valid=0, instr=`NOP_WORD`), unless `stall`.
- `stall`=1, no redirect: PC, IF/ID and FSM state held; `imem_ready` ignored. A stalled RUN re-fetches the same address next cycle.
- `redirect`=1 in RUN (priority over `stall`): PC ← `redirect_target`; IF/ID per Configuration; FSM stays RUN.
- `redirect`=1 in WAIT: target latched in `pend_target`, `pend`←1; address unchanged.
  - A later redirect before ready overwrites `pend_target`.
  - When ready arrives: that word is discarded (IF/ID bubble), PC ← `pend_target`, `pend`←0, →RUN.
- PC+4 wraps modulo 2^32; no alignment check; bits [1:0] are passed as given.
- Field outputs are pure slices of `id_instr`, so a bubble yields all-zero fields when `NOP_WORD`=0.

## Timing
- Reset values:
  - PC=`RESET_PC`, `imem_addr`=`RESET_PC`, `imem_req`=0.
  - `id_valid`=0, `id_instr`=`NOP_WORD`, `id_pc_plus4`=0.
  - State BOOT, `pend`=0.
- Latency: word accepted at edge N (ready=1) appears on `id_*` after edge N, one cycle.
- Zero-wait memory gives one instruction per cycle after the BOOT cycle.
- Reset mid-WAIT or mid-pending-redirect: everything returns to reset values immediately. A later `imem_ready` is ignored until RUN.

## Configuration
- `DELAY_SLOT_EN` defined: on a redirect in RUN with `imem_ready`=1, the fetched word (delay slot) is captured into IF/ID with valid=1. In the WAIT pending case, the arriving word is also kept as the delay slot.
- Not defined: the word fetched in the redirect cycle, or arriving for a pending redirect, is squashed. IF/ID gets a bubble.

## Structure
- Shared package `fetch_pkg`:
  - state enum {BOOT, RUN, WAIT}
  - `NOP_WORD` default
  - instruction field bit-position constants, reused by decode
- One sub-module, `if_id_reg`:
  - inputs: capture, bubble, hold
  - outputs: valid, instr, pc_plus4
  - same async active-low reset
- PC, FSM and pending-redirect logic stay in the top module.

## Test plan
- Reset release, `imem_ready` tied 1, memory word = address → BOOT cycle with req=0. Addresses then run 0,4,8,…; `id_instr`=0,4,8 with one-cycle lag and `id_valid`=1.
- `imem_ready` low for 3 cycles at address 0x10 → `imem_addr` stays 0x10 for all 3 cycles, 3 bubbles appear, then 0x10 is captured and address moves to 0x14.
- `stall` high 2 cycles while IF/ID holds 0x8 → `id_instr`=0x8 held, `imem_addr` held at 0xC, then fetch resumes at 0xC.
- `redirect` with target 0x100 while ready=1 at 0x20 → next address is 0x100. Without macro, IF/ID gets a bubble; with `DELAY_SLOT_EN`, word 0x20 is captured with valid=1.
- `redirect` to 0x200 during WAIT at 0x30, then ready after 2 cycles → address held at 0x30 until ready, then moves to 0x200. The 0x30 word is dropped without the macro and kept with it.
- Instruction 0x8C22FFFC captured → `id_opcode`=0x23, `id_rs`=1, `id_rt`=2, `id_imm16`=0xFFFC.
